ro_block_gen: RTL and testbench



---
 rtl/ro_pkg.sv | 21 ++
 rtl/ro_fifo.sv | 81 ++++++++
 rtl/ro_block_gen.sv | 98 +++++++++
 tb/tb_ro_block_gen.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ro_pkg.sv
// Shared constants and helpers for the readout block generator.
package ro_pkg;

  // Default geometry of a readout core.
  localparam int RO_GRAY_W = 19;
  localparam int RO_DEPTH  = 4;

  // Word layout: eve bits occupy the low half, pol_eve bits the high half.
  localparam int RO_EVE_OFS = 0;

  // Width of one buffered sample word for a given channel count.
  function automatic int ro_word_w(input int num_ch);
    return 2 * num_ch;
  endfunction

  // Bit offset of the pol_eve field within a sample word.
  function automatic int ro_pol_ofs(input int num_ch);
    return num_ch;
  endfunction

endpackage

// File: rtl/ro_fifo.sv
// Small synchronous FIFO with registered storage, combinational head and a
// separate occupancy counter. Pushes into a full FIFO are accepted only when
// a pop retires the head in the same cycle; pops from an empty FIFO are ignored.
module ro_fifo
  import ro_pkg::*;
#(
  parameter int W     = 4,
  parameter int DEPTH = RO_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] fill
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty = (fill_q == '0);
  assign full  = (fill_q == CNT_W'(DEPTH));
  assign fill  = fill_q;
  assign head  = mem_q[rd_ptr_q];

  // Qualify requests and compute next pointers, count and storage contents.
  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_ok && !pop_ok) begin
      fill_d = fill_q + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      fill_d = fill_q - CNT_W'(1);
    end
  end

  // Control state: pointers and occupancy, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Storage array; contents are only observable through valid entries.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/ro_block_gen.sv
// Per-core readout block: samples channel pairs on both edges of the selected
// gray-counter bit, buffers them and drives the shared bus only when granted.
module ro_block_gen
  import ro_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int GRAY_W   = RO_GRAY_W,
  parameter int CORE_IDX = 4,
  parameter int DEPTH    = RO_DEPTH,
  parameter int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic              clk_master,
  input  logic              reset,
  input  logic [GRAY_W-1:0] gray,
  input  logic              en,
  input  logic [NUM_CH-1:0] in_eve,
  input  logic [NUM_CH-1:0] in_pol_eve,
  input  logic              rd_grant,
  input  logic              clr_ovf,
  output logic              rd_req,
  output logic [NUM_CH-1:0] out_mux_eve,
  output logic [NUM_CH-1:0] out_mux_pol_eve,
  output logic              overflow,
  output logic [CNT_W-1:0]  fill
);

  localparam int WORD_W  = ro_word_w(NUM_CH);
  localparam int POL_OFS = ro_pol_ofs(NUM_CH);

  logic              gray_q, gray_d;
  logic              overflow_q, overflow_d;
  logic              edge_det;
  logic              push_req;
  logic              pop;
  logic              drop;
  logic              full;
  logic              empty;
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] head;

  assign wr_word = {in_pol_eve, in_eve};
  assign rd_req  = !empty;
  assign pop     = rd_req && rd_grant;

  ro_fifo #(
    .W     (WORD_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk_master),
    .rst   (reset),
    .push  (push_req),
    .pop   (pop),
    .din   (wr_word),
    .head  (head),
    .full  (full),
    .empty (empty),
    .fill  (fill)
  );

  // Edge detect on the tapped gray bit; a drop occurs when a push finds no room.
  always_comb begin
    gray_d     = gray[CORE_IDX];
    edge_det   = gray[CORE_IDX] ^ gray_q;
    push_req   = edge_det && en;
    drop       = push_req && full && !pop;
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  // Edge-detect history and sticky overflow flag.
  always_ff @(posedge clk_master or posedge reset) begin
    if (reset) begin
      gray_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      gray_q     <= gray_d;
      overflow_q <= overflow_d;
    end
  end

  // Bus drive is AND-gated by an active grant on a non-empty FIFO.
  always_comb begin
    out_mux_eve     = '0;
    out_mux_pol_eve = '0;
    if (pop) begin
      out_mux_eve     = head[RO_EVE_OFS +: NUM_CH];
      out_mux_pol_eve = head[POL_OFS +: NUM_CH];
    end
  end

  assign overflow = overflow_q;

endmodule

// File: tb/tb_ro_block_gen.sv
// Directed bench for ro_block_gen with default geometry (NUM_CH=2, CORE_IDX=4, DEPTH=4).
module tb_ro_block_gen;

  logic        clk_master = 1'b0;
  logic        reset;
  logic [18:0] gray;
  logic        en;
  logic [1:0]  in_eve;
  logic [1:0]  in_pol_eve;
  logic        rd_grant;
  logic        clr_ovf;
  logic        rd_req;
  logic [1:0]  out_mux_eve;
  logic [1:0]  out_mux_pol_eve;
  logic        overflow;
  logic [2:0]  fill;

  int n_checks = 0;
  int n_errors = 0;

  ro_block_gen #(
    .NUM_CH   (2),
    .GRAY_W   (19),
    .CORE_IDX (4),
    .DEPTH    (4),
    .CNT_W    (3)
  ) dut (
    .clk_master      (clk_master),
    .reset           (reset),
    .gray            (gray),
    .en              (en),
    .in_eve          (in_eve),
    .in_pol_eve      (in_pol_eve),
    .rd_grant        (rd_grant),
    .clr_ovf         (clr_ovf),
    .rd_req          (rd_req),
    .out_mux_eve     (out_mux_eve),
    .out_mux_pol_eve (out_mux_pol_eve),
    .overflow        (overflow),
    .fill            (fill)
  );

  always #5 clk_master = ~clk_master;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_master);
    #1;
  endtask

  // Present a word and toggle gray[4] so the next clock edge samples it.
  task automatic set_edge(input logic [3:0] w);
    in_eve     = w[1:0];
    in_pol_eve = w[3:2];
    gray[4]    = ~gray[4];
  endtask

  task automatic push_word(input logic [3:0] w);
    set_edge(w);
    tick();
  endtask

  function automatic logic [3:0] bus_word();
    return {out_mux_pol_eve, out_mux_eve};
  endfunction

  initial begin
    reset      = 1'b1;
    gray       = '0;
    en         = 1'b1;
    in_eve     = '0;
    in_pol_eve = '0;
    rd_grant   = 1'b0;
    clr_ovf    = 1'b0;
    tick();
    tick();
    chk("rst_fill", fill, 0);
    chk("rst_req", rd_req, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_bus", bus_word(), 0);
    reset = 1'b0;
    tick();

    // Basic capture
    push_word(4'b1001);
    chk("cap_req", rd_req, 1);
    chk("cap_fill", fill, 1);
    chk("cap_bus_nogrant", bus_word(), 0);
    rd_grant = 1'b1;
    #1;
    chk("cap_eve", out_mux_eve, 2'b01);
    chk("cap_pol", out_mux_pol_eve, 2'b10);
    tick();
    chk("cap_fill_after", fill, 0);
    chk("cap_req_after", rd_req, 0);
    chk("cap_bus_empty", bus_word(), 0);
    rd_grant = 1'b0;

    // Both edges counted, strict ordering
    push_word(4'h1);
    push_word(4'h2);
    chk("both_fill", fill, 2);
    rd_grant = 1'b1;
    #1;
    chk("both_a", bus_word(), 4'h1);
    tick();
    chk("both_b", bus_word(), 4'h2);
    tick();
    chk("both_drained", fill, 0);
    rd_grant = 1'b0;
    gray[3] = ~gray[3];
    tick();
    gray[5] = ~gray[5];
    tick();
    chk("other_bits", fill, 0);

    // Overflow on the 5th edge
    for (int i = 1; i <= 5; i++) begin
      push_word(4'(i));
      if (i == 4) begin
        chk("ovf_fill4", fill, 4);
        chk("ovf_not_yet", overflow, 0);
      end
    end
    chk("ovf_fill", fill, 4);
    chk("ovf_set", overflow, 1);
    rd_grant = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("ovf_drain", bus_word(), 32'(i));
      tick();
    end
    rd_grant = 1'b0;
    chk("ovf_drained", fill, 0);
    chk("ovf_sticky", overflow, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_clr", overflow, 0);

    // Full with simultaneous push and pop
    for (int i = 6; i <= 9; i++) push_word(4'(i));
    chk("fpp_fill_pre", fill, 4);
    set_edge(4'hA);
    rd_grant = 1'b1;
    #1;
    chk("fpp_head", bus_word(), 4'h6);
    tick();
    chk("fpp_fill", fill, 4);
    chk("fpp_ovf", overflow, 0);
    for (int i = 0; i < 4; i++) begin
      chk("fpp_drain", bus_word(), 32'(7 + i));
      tick();
    end
    chk("fpp_drained", fill, 0);

    // Enable low with grant high on empty FIFO
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_word(4'hF);
      chk("en_fill", fill, 0);
      chk("en_req", rd_req, 0);
      chk("en_bus", bus_word(), 0);
    end
    en = 1'b1;
    rd_grant = 1'b0;

    // clr_ovf coinciding with a drop: set wins
    for (int i = 1; i <= 4; i++) push_word(4'(i));
    clr_ovf = 1'b1;
    push_word(4'h5);
    clr_ovf = 1'b0;
    chk("clr_vs_drop", overflow, 1);
    rd_grant = 1'b1;
    tick();
    chk("pre_rst_fill", fill, 3);
    chk("pre_rst_ovf", overflow, 1);

    // Asynchronous reset mid-cycle
    #3;
    gray  = '0;
    reset = 1'b1;
    #1;
    chk("arst_fill", fill, 0);
    chk("arst_req", rd_req, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_bus", bus_word(), 0);
    rd_grant = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_idle", fill, 0);
    push_word(4'h3);
    chk("post_rst_push", fill, 1);
    tick();
    chk("post_rst_once", fill, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
